// File: rtl/mpu_pkg.sv
// Shared constants, PIO field layouts and FSM encoding for the MPU host sequencer.
// Optional build macro MPU_SEQ_TIMEOUT_EN enables the handshake watchdog in mpu_host_sequencer.
package mpu_pkg;

   localparam int unsigned N_BITS         = 200;
   localparam int unsigned N_BYTES        = N_BITS / 8;
   localparam int unsigned TIMEOUT_CYCLES = 4096;

   localparam int unsigned PIO_W      = 32;
   localparam int unsigned OP_W       = 3;
   localparam int unsigned BIT_CNT_W  = 8;
   localparam int unsigned BYTE_CNT_W = 5;
   localparam int unsigned TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);

   localparam int unsigned PIO_START   = 31;
   localparam int unsigned PIO_SIZE    = 30;
   localparam int unsigned PIO_OP_MSB  = 29;
   localparam int unsigned PIO_OP_LSB  = 27;
   localparam int unsigned PIO_ACK     = 26;
   localparam int unsigned PIO_FLAG    = 31;
   localparam int unsigned PIO_IDX_MSB = 30;
   localparam int unsigned PIO_IDX_LSB = 26;

   // Host-to-coprocessor word, msb first
   typedef struct packed {
      logic                 start;
      logic                 size;
      logic [OP_W-1:0]      op;
      logic                 ack;
      logic [16:0]          rsvd;
      logic [BIT_CNT_W-1:0] bit_pos;
      logic                 bit_val;
   } pio_out_t;

   // Coprocessor-to-host word, msb first
   typedef struct packed {
      logic                  flag;
      logic [BYTE_CNT_W-1:0] idx;
      logic [17:0]           rsvd;
      logic [7:0]            data;
   } pio_in_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CMD       = 3'd1,
      ST_SEND_A    = 3'd2,
      ST_SEND_B    = 3'd3,
      ST_WAIT_FLAG = 3'd4,
      ST_WAIT_CLR  = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

endpackage

// File: rtl/mpu_host_sequencer_if.sv
// Command, PIO and result bundle between the host sequencer (master) and its surroundings (slave).
interface mpu_host_sequencer_if;
   import mpu_pkg::*;

   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [OP_W-1:0]      cmd_op;
   logic                 cmd_size2;
   logic [N_BITS-1:0]    cmd_matrix_a;
   logic [N_BITS-1:0]    cmd_matrix_b;
   logic [PIO_W-1:0]     pio_out;
   logic [PIO_W-1:0]     pio_in;
   logic                 res_valid;
   logic                 res_ready;
   logic [N_BITS-1:0]    res_data;
   logic                 busy;
   logic                 error;

   modport master (
      input  cmd_valid, cmd_op, cmd_size2, cmd_matrix_a, cmd_matrix_b, pio_in, res_ready,
      output cmd_ready, pio_out, res_valid, res_data, busy, error
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_size2, cmd_matrix_a, cmd_matrix_b, pio_in, res_ready,
      input  cmd_ready, pio_out, res_valid, res_data, busy, error
   );

endinterface

// File: rtl/mpu_pio_strober.sv
// Two-cycle start strobe: high for the cycle after go, low for the next; done flags the low cycle.
module mpu_pio_strober (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_go,
   output logic o_start,
   output logic o_done_c
);

   logic r_hi;
   logic r_lo;

   // go is ignored during the high cycle so a write can never be shortened
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_hi <= 1'b0;
         r_lo <= 1'b0;
      end else begin
         r_hi <= i_go & ~r_hi;
         r_lo <= r_hi;
      end
   end

   assign o_start  = r_hi;
   assign o_done_c = r_lo;

endmodule

// File: rtl/mpu_host_sequencer.sv
// Host-side MPU PIO driver: bit-serial operand load, flag/ack byte readback, valid/ready result.
// Build macro MPU_SEQ_TIMEOUT_EN adds a watchdog on the readback handshake.
module mpu_host_sequencer
   import mpu_pkg::*;
(
   input  logic                  i_clock,
   input  logic                  i_reset,
   mpu_host_sequencer_if.master  bus
);

   localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(N_BITS - 1);
   localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(N_BYTES - 1);

   state_t                r_state,      w_state_nxt;
   logic [N_BITS-1:0]     r_a,          w_a_nxt;
   logic [N_BITS-1:0]     r_b,          w_b_nxt;
   logic [N_BITS-1:0]     r_res,        w_res_nxt;
   logic [OP_W-1:0]       r_op,         w_op_nxt;
   logic                  r_size,       w_size_nxt;
   logic                  r_bit_val,    w_bit_val_nxt;
   logic [BIT_CNT_W-1:0]  r_bit_cnt,    w_bit_cnt_nxt;
   logic [BYTE_CNT_W-1:0] r_byte_cnt,   w_byte_cnt_nxt;
   logic                  r_ack,        w_ack_nxt;
   logic                  r_error,      w_error_nxt;
   logic                  r_res_valid,  w_res_valid_nxt;
   logic                  r_cmd_ready,  w_cmd_ready_nxt;
   logic                  r_busy,       w_busy_nxt;

   logic                  w_go;
   logic                  w_start;
   logic                  w_done_c;
   logic                  w_timeout;
   logic [BIT_CNT_W-1:0]  w_bit_inc;
   pio_in_t               w_in;
   pio_out_t              w_pio;
   logic                  w_unused_rsvd;

   assign w_in          = pio_in_t'(bus.pio_in);
   assign w_unused_rsvd = ^w_in.rsvd;
   assign w_bit_inc     = r_bit_cnt + BIT_CNT_W'(1);

   mpu_pio_strober u_strober (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_go     (w_go),
      .o_start  (w_start),
      .o_done_c (w_done_c)
   );

`ifdef MPU_SEQ_TIMEOUT_EN
   logic [TIMER_W-1:0] r_timer;
   logic               w_stay;

   // Counts cycles spent in one wait state without the event that would leave it
   assign w_stay = (r_state == ST_WAIT_FLAG && !w_in.flag) ||
                   (r_state == ST_WAIT_CLR  &&  w_in.flag);
   assign w_timeout = w_stay && (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_timer <= '0;
      end else if (w_stay && !w_timeout) begin
         r_timer <= r_timer + TIMER_W'(1);
      end else begin
         r_timer <= '0;
      end
   end
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state and datapath updates
   always_comb begin
      w_state_nxt     = r_state;
      w_a_nxt         = r_a;
      w_b_nxt         = r_b;
      w_res_nxt       = r_res;
      w_op_nxt        = r_op;
      w_size_nxt      = r_size;
      w_bit_val_nxt   = r_bit_val;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_byte_cnt_nxt  = r_byte_cnt;
      w_ack_nxt       = 1'b0;
      w_error_nxt     = r_error;
      w_res_valid_nxt = r_res_valid;
      w_go            = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (bus.cmd_valid && r_cmd_ready) begin
               w_a_nxt       = bus.cmd_matrix_a;
               w_b_nxt       = bus.cmd_matrix_b;
               w_op_nxt      = bus.cmd_op;
               w_size_nxt    = bus.cmd_size2;
               w_bit_cnt_nxt = '0;
               w_bit_val_nxt = 1'b0;
               w_go          = 1'b1;
               w_state_nxt   = ST_CMD;
            end
         end
         ST_CMD: begin
            if (w_done_c) begin
               w_bit_cnt_nxt = '0;
               w_bit_val_nxt = r_a[0];
               w_go          = 1'b1;
               w_state_nxt   = ST_SEND_A;
            end
         end
         ST_SEND_A: begin
            if (w_done_c) begin
               w_go = 1'b1;
               if (r_bit_cnt == LAST_BIT) begin
                  w_bit_cnt_nxt = '0;
                  w_bit_val_nxt = r_b[0];
                  w_state_nxt   = ST_SEND_B;
               end else begin
                  w_bit_cnt_nxt = w_bit_inc;
                  w_bit_val_nxt = r_a[w_bit_inc];
               end
            end
         end
         ST_SEND_B: begin
            if (w_done_c) begin
               if (r_bit_cnt == LAST_BIT) begin
                  w_bit_cnt_nxt  = '0;
                  w_bit_val_nxt  = 1'b0;
                  w_byte_cnt_nxt = '0;
                  w_state_nxt    = ST_WAIT_FLAG;
               end else begin
                  w_go          = 1'b1;
                  w_bit_cnt_nxt = w_bit_inc;
                  w_bit_val_nxt = r_b[w_bit_inc];
               end
            end
         end
         ST_WAIT_FLAG: begin
            if (w_in.flag) begin
               if (w_in.idx == r_byte_cnt) begin
                  w_res_nxt[{r_byte_cnt, 3'b000} +: 8] = w_in.data;
                  w_ack_nxt   = 1'b1;
                  w_state_nxt = ST_WAIT_CLR;
               end else begin
                  w_error_nxt = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_WAIT_CLR: begin
            if (!w_in.flag) begin
               if (r_byte_cnt == LAST_BYTE) begin
                  w_res_valid_nxt = 1'b1;
                  w_state_nxt     = ST_DONE;
               end else begin
                  w_byte_cnt_nxt = r_byte_cnt + BYTE_CNT_W'(1);
                  w_state_nxt    = ST_WAIT_FLAG;
               end
            end
         end
         ST_DONE: begin
            if (bus.res_ready) begin
               w_res_valid_nxt = 1'b0;
               w_state_nxt     = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      if (w_timeout) begin
         w_error_nxt = 1'b1;
         w_state_nxt = ST_IDLE;
      end

      // IDLE drives a quiet PIO word
      if (w_state_nxt == ST_IDLE) begin
         w_op_nxt      = '0;
         w_size_nxt    = 1'b0;
         w_bit_val_nxt = 1'b0;
         w_bit_cnt_nxt = '0;
         w_ack_nxt     = 1'b0;
      end

      w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
      w_busy_nxt      = (w_state_nxt != ST_IDLE);
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_res       <= '0;
         r_op        <= '0;
         r_size      <= 1'b0;
         r_bit_val   <= 1'b0;
         r_bit_cnt   <= '0;
         r_byte_cnt  <= '0;
         r_ack       <= 1'b0;
         r_error     <= 1'b0;
         r_res_valid <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_a         <= w_a_nxt;
         r_b         <= w_b_nxt;
         r_res       <= w_res_nxt;
         r_op        <= w_op_nxt;
         r_size      <= w_size_nxt;
         r_bit_val   <= w_bit_val_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_byte_cnt  <= w_byte_cnt_nxt;
         r_ack       <= w_ack_nxt;
         r_error     <= w_error_nxt;
         r_res_valid <= w_res_valid_nxt;
         r_cmd_ready <= w_cmd_ready_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   // PIO word assembled purely from registered fields
   always_comb begin
      w_pio         = '0;
      w_pio.start   = w_start;
      w_pio.size    = r_size;
      w_pio.op      = r_op;
      w_pio.ack     = r_ack;
      w_pio.bit_pos = r_bit_cnt;
      w_pio.bit_val = r_bit_val;
   end

   assign bus.pio_out   = w_pio;
   assign bus.cmd_ready = r_cmd_ready;
   assign bus.res_valid = r_res_valid;
   assign bus.res_data  = r_res;
   assign bus.busy      = r_busy;
   assign bus.error     = r_error;

endmodule

// File: tb/tb_mpu_host_sequencer.sv
// Self-checking bench for mpu_host_sequencer: directed and random commands against a coprocessor model.
module tb_mpu_host_sequencer;
   import mpu_pkg::*;

   typedef logic [N_BITS-1:0] vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mpu_host_sequencer_if bus();

   mpu_host_sequencer dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   // Passive PIO/result observer
   int          strobes  = 0;
   int          start_hi = 0;
   int          acks     = 0;
   int          clash    = 0;
   int          rsvd     = 0;
   int          unstable = 0;
   int          rv_rise  = 0;
   logic        prev_start = 1'b0;
   logic        prev_rv    = 1'b0;
   logic [31:0] prev_w     = '0;
   logic [31:0] q_w[$];

   always @(posedge clk) begin
      if (bus.pio_out[31] && !prev_start) begin
         strobes++;
         q_w.push_back(bus.pio_out);
      end
      if (bus.pio_out[31]) start_hi++;
      if (bus.pio_out[26]) acks++;
      if (bus.pio_out[31] && bus.pio_out[26]) clash++;
      if (bus.pio_out[25:9] != 17'd0) rsvd++;
      if (prev_start && !bus.pio_out[31] && bus.pio_out[30:0] != prev_w[30:0]) unstable++;
      if (bus.res_valid && !prev_rv) rv_rise++;
      prev_start = bus.pio_out[31];
      prev_w     = bus.pio_out;
      prev_rv    = bus.res_valid;
   end

   task automatic chk(input string tag, input vec_t obs, input vec_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Coprocessor behaviour: the result it returns for a given operation
   function automatic vec_t mpu_model(input logic [2:0] op, input logic size, input vec_t a, input vec_t b);
      vec_t r;
      case (op)
         3'd0:    r = a + b;
         3'd1:    r = a - b;
         3'd2:    r = a ^ b;
         3'd3:    r = a & b;
         default: r = a | (b << op);
      endcase
      if (size) r = ~r;
      return r;
   endfunction

   function automatic vec_t rand_vec();
      vec_t v = '0;
      for (int i = 0; i < 7; i++) v = {v[N_BITS-33:0], 32'($urandom)};
      return v;
   endfunction

   task automatic do_load(input logic [2:0] op, input logic size, input vec_t a, input vec_t b,
                          input bit flag_pre, input bit poke,
                          output vec_t rx_a, output vec_t rx_b,
                          output logic [2:0] rx_op, output logic rx_size);
      int          bs, bh, bq, bad;
      logic [31:0] w;
      vec_t        pre;
      pre = mpu_model(op, size, a, b);
      @(negedge clk);
      bs = strobes; bh = start_hi; bq = q_w.size();
      bus.cmd_op = op; bus.cmd_size2 = size;
      bus.cmd_matrix_a = a; bus.cmd_matrix_b = b;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_matrix_a = ~a; bus.cmd_matrix_b = ~b; bus.cmd_op = ~op;
      chk("first_strobe", vec_t'(bus.pio_out), vec_t'({1'b1, size, op, 27'd0}));
      chk("cmd_ready_busy", vec_t'(bus.cmd_ready), vec_t'(0));
      for (int i = 1; i <= 802; i++) begin
         if (poke && i == 100) bus.cmd_valid = 1'b1;
         if (poke && i == 106) bus.cmd_valid = 1'b0;
         if (flag_pre && i == 795) bus.pio_in = {1'b1, 5'd0, 18'd0, pre[7:0]};
         @(negedge clk);
      end
      chk("strobe_count", vec_t'(strobes - bs), vec_t'(401));
      chk("start_hi_cycles", vec_t'(start_hi - bh), vec_t'(401));
      chk("busy_after_load", vec_t'(bus.busy), vec_t'(1));
      chk("start_low_after_load", vec_t'(bus.pio_out[31]), vec_t'(0));
      rx_a = '0; rx_b = '0; rx_op = '0; rx_size = 1'b0; bad = 0;
      if (q_w.size() < bq + 401) begin
         bad = 1000;
      end else begin
         w = q_w[bq];
         rx_op = w[29:27]; rx_size = w[30];
         if (w[8:0] != 9'd0) bad++;
         for (int i = 0; i < 200; i++) begin
            w = q_w[bq + 1 + i];
            if (w[8:1] != 8'(i) || w[29:27] != rx_op || w[30] != rx_size) bad++;
            rx_a[i] = w[0];
            w = q_w[bq + 201 + i];
            if (w[8:1] != 8'(i) || w[29:27] != rx_op || w[30] != rx_size) bad++;
            rx_b[i] = w[0];
         end
      end
      chk("bit_pos_order", vec_t'(bad), vec_t'(0));
      chk("rx_op", vec_t'(rx_op), vec_t'(op));
      chk("rx_size", vec_t'(rx_size), vec_t'(size));
      chk("rx_matrix_a", rx_a, a);
      chk("rx_matrix_b", rx_b, b);
   endtask

   task automatic do_readback(input vec_t dev);
      int ba, missing;
      bit got;
      ba = acks; missing = 0;
      for (int k = 0; k < 25; k++) begin
         bus.pio_in = {1'b1, 5'(k), 18'd0, dev[8*k +: 8]};
         got = 1'b0;
         for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.pio_out[26]) got = 1'b1;
         end
         if (!got) missing++;
         bus.pio_in = '0;
         @(negedge clk);
      end
      chk("ack_missing", vec_t'(missing), vec_t'(0));
      chk("ack_count", vec_t'(acks - ba), vec_t'(25));
      chk("res_valid_rise", vec_t'(bus.res_valid), vec_t'(1));
   endtask

   task automatic finish_result(input vec_t exp, input int rv_base);
      int held;
      chk("res_data", bus.res_data, exp);
      held = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.res_valid) held++;
      end
      chk("res_valid_hold", vec_t'(held), vec_t'(10));
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("res_valid_clear", vec_t'(bus.res_valid), vec_t'(0));
      chk("cmd_ready_back", vec_t'(bus.cmd_ready), vec_t'(1));
      chk("res_valid_once", vec_t'(rv_rise - rv_base), vec_t'(1));
   endtask

   task automatic full_op(input logic [2:0] op, input logic size, input vec_t a, input vec_t b,
                          input bit flag_pre, input bit poke);
      vec_t        ra, rb;
      logic [2:0]  rop;
      logic        rsz;
      int          rvb;
      rvb = rv_rise;
      do_load(op, size, a, b, flag_pre, poke, ra, rb, rop, rsz);
      do_readback(mpu_model(rop, rsz, ra, rb));
      finish_result(mpu_model(op, size, a, b), rvb);
   endtask

   initial begin
      vec_t        ra, rb, a, b;
      logic [2:0]  rop;
      logic        rsz;
      int          ba, bs, n;
      logic [31:0] w;

      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_size2 = 1'b0;
      bus.cmd_matrix_a = '0; bus.cmd_matrix_b = '0;
      bus.pio_in = '0; bus.res_ready = 1'b0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_pio_out", vec_t'(bus.pio_out), vec_t'(0));
      chk("reset_cmd_ready", vec_t'(bus.cmd_ready), vec_t'(1));
      chk("reset_res_valid", vec_t'(bus.res_valid), vec_t'(0));
      chk("reset_error", vec_t'(bus.error), vec_t'(0));
      chk("reset_busy", vec_t'(bus.busy), vec_t'(0));
      chk("reset_res_data", bus.res_data, vec_t'(0));

      // Directed load pattern with a busy-time command that must be ignored
      full_op(3'b010, 1'b1, vec_t'(1), '1, 1'b0, 1'b1);

      // Random operations, one with the flag already raised on readback entry
      for (int r = 0; r < 3; r++) begin
         full_op(3'($urandom), 1'($urandom), rand_vec(), rand_vec(), (r == 1), (r == 2));
      end

      // Byte index mismatch on the first byte
      do_load(3'($urandom), 1'($urandom), rand_vec(), rand_vec(), 1'b0, 1'b0, ra, rb, rop, rsz);
      ba = acks;
      bus.pio_in = {1'b1, 5'd3, 18'd0, 8'hA5};
      @(negedge clk);
      chk("mismatch_error", vec_t'(bus.error), vec_t'(1));
      chk("mismatch_idle_busy", vec_t'(bus.busy), vec_t'(0));
      chk("mismatch_cmd_ready", vec_t'(bus.cmd_ready), vec_t'(1));
      chk("mismatch_pio_out", vec_t'(bus.pio_out), vec_t'(0));
      bus.pio_in = '0;
      @(negedge clk);
      chk("mismatch_no_ack", vec_t'(acks - ba), vec_t'(0));
      chk("mismatch_no_result", vec_t'(bus.res_valid), vec_t'(0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("error_cleared_by_reset", vec_t'(bus.error), vec_t'(0));

      // Reset in the middle of SEND_A at bit 57
      a = rand_vec(); b = rand_vec();
      bs = strobes;
      bus.cmd_op = 3'd5; bus.cmd_size2 = 1'b0;
      bus.cmd_matrix_a = a; bus.cmd_matrix_b = b;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      n = 0;
      while ((strobes - bs) < 59 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("reach_bit57", vec_t'((strobes - bs) >= 59), vec_t'(1));
      w = (q_w.size() > 0) ? q_w[q_w.size() - 1] : 32'd0;
      chk("bit57_pos", vec_t'(w[8:1]), vec_t'(57));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midreset_pio_out", vec_t'(bus.pio_out), vec_t'(0));
      chk("midreset_cmd_ready", vec_t'(bus.cmd_ready), vec_t'(1));
      chk("midreset_busy", vec_t'(bus.busy), vec_t'(0));
      full_op(3'($urandom), 1'($urandom), rand_vec(), rand_vec(), 1'b0, 1'b0);

      // Coprocessor never answers
      do_load(3'($urandom), 1'($urandom), rand_vec(), rand_vec(), 1'b0, 1'b0, ra, rb, rop, rsz);
`ifdef MPU_SEQ_TIMEOUT_EN
      n = 0;
      while (!bus.error && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycles", vec_t'(n), vec_t'(TIMEOUT_CYCLES));
      chk("timeout_error", vec_t'(bus.error), vec_t'(1));
      chk("timeout_pio_out", vec_t'(bus.pio_out), vec_t'(0));
      chk("timeout_busy", vec_t'(bus.busy), vec_t'(0));
`else
      repeat (10000) @(negedge clk);
      chk("wait_busy", vec_t'(bus.busy), vec_t'(1));
      chk("wait_error", vec_t'(bus.error), vec_t'(0));
`endif

      chk("start_ack_overlap", vec_t'(clash), vec_t'(0));
      chk("reserved_bits", vec_t'(rsvd), vec_t'(0));
      chk("strobe_field_stability", vec_t'(unstable), vec_t'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
